// File: rtl/gate_sweep_unit_if.sv
// Result stream of gate_sweep_unit: one (a, b, y) beat per valid/ready transfer.
interface gate_sweep_unit_if #(
   parameter int unsigned WIDTH = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [WIDTH-1:0] out_y;
   logic             out_last;

   modport master (
      output out_valid, out_a, out_b, out_y, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_a, out_b, out_y, out_last,
      output out_ready
   );
endinterface

// File: rtl/gate_sweep_unit.sv
// Truth-table generator: sweeps all (a, b) operand pairs, evaluates the latched
// gate and streams each beat, counting all-ones results.
module gate_sweep_unit #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2:0]           op_sel,
   input  logic                 invert_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH:0]     match_count,
   gate_sweep_unit_if.master    out_if
);

   localparam int unsigned IW = 2 * WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IW-1:0]    r_idx;
   logic [2:0]       r_op;
   logic             r_inv;
   logic [IW:0]      r_match;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_y;
   logic             w_valid;
   logic             w_xfer;
   logic             w_is_max;
   logic             w_all_ones;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_xfer && w_is_max) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_valid = (r_state == S_RUN);
      busy    = (r_state != S_IDLE);
      done    = (r_state == S_DONE);
   end

   always_comb begin
      w_a = r_idx[IW-1 -: WIDTH];
      w_b = r_idx[WIDTH-1:0] ^ {WIDTH{r_inv}};
      case (r_op)
         3'd0:    w_y = ~(w_a | w_b);
         3'd1:    w_y = ~(w_a & w_b);
         3'd2:    w_y = w_a & w_b;
         3'd3:    w_y = w_a | w_b;
         3'd4:    w_y = w_a ^ w_b;
         3'd5:    w_y = ~(w_a ^ w_b);
         3'd6:    w_y = w_a & ~w_b;
         default: w_y = ~w_a | w_b;
      endcase
      w_is_max   = (r_idx == '1);
      w_xfer     = w_valid & out_if.out_ready;
      w_all_ones = (w_y == '1);
   end

   // Beat fields are gated by valid so they read zero outside RUN (incl. reset).
   always_comb begin
      out_if.out_valid = w_valid;
      out_if.out_a     = w_valid ? w_a : '0;
      out_if.out_b     = w_valid ? w_b : '0;
      out_if.out_y     = w_valid ? w_y : '0;
      out_if.out_last  = w_valid & w_is_max;
      match_count      = r_match;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx   <= '0;
         r_op    <= '0;
         r_inv   <= 1'b0;
         r_match <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_idx   <= '0;
         r_op    <= op_sel;
         r_inv   <= invert_b;
         r_match <= '0;
      end else if (w_xfer) begin
         r_match <= r_match + {{IW{1'b0}}, w_all_ones};
         if (!w_is_max) r_idx <= r_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Scoreboard bench for gate_sweep_unit: expected beats come from per-op truth
// tables; a negedge monitor pops and compares every transferred beat.
module tb_gate_sweep_unit;
   localparam int unsigned W  = 2;
   localparam int unsigned NB = 1 << (2 * W);
   localparam int unsigned MX = (1 << W) - 1;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2:0]     op_sel;
   logic           invert_b;
   logic           busy;
   logic           done;
   logic [2*W:0]   match_count;

   gate_sweep_unit_if #(.WIDTH(W)) bus ();

   gate_sweep_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op_sel      (op_sel),
      .invert_b    (invert_b),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .out_if      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned a;
      int unsigned b;
      int unsigned y;
      int unsigned last;
   } beat_t;

   beat_t       beat_q[$];
   int unsigned cnt_q[$];
   logic [3:0]  ttab[8];
   int          checks = 0;
   int          passes = 0;
   int unsigned done_cnt = 0;
   time         done_time = 0;
   time         rise_time = 0;
   bit          rnd_ready = 0;
   bit          stall_armed = 0;
   int          stall_cnt = 0;

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
   endtask

   // Reference: each output bit is looked up in the gate's 2-input truth table.
   task automatic push_sweep(input int unsigned op, input int unsigned inv);
      int unsigned m = 0;
      logic [3:0]  t;
      t = ttab[op];
      for (int unsigned a = 0; a <= MX; a++) begin
         for (int unsigned b = 0; b <= MX; b++) begin
            beat_t bt;
            bt.a = a;
            bt.b = inv != 0 ? (MX - b) : b;
            bt.y = 0;
            for (int unsigned k = 0; k < W; k++)
               bt.y += int'(t[((a >> k) & 1) * 2 + ((bt.b >> k) & 1)]) << k;
            bt.last = (a == MX && b == MX) ? 1 : 0;
            if (bt.y == MX) m++;
            beat_q.push_back(bt);
         end
      end
      cnt_q.push_back(m);
   endtask

   always @(posedge clk) begin
      #1;
      if (stall_armed && bus.out_valid && bus.out_a == 0 && bus.out_b == 2) begin
         stall_cnt   = 3;
         stall_armed = 0;
      end
      if (stall_cnt > 0) begin
         bus.out_ready = 1'b0;
         stall_cnt--;
      end else if (rnd_ready) bus.out_ready = ($urandom % 4) != 0;
      else bus.out_ready = 1'b1;
   end

   bit         prev_stall = 0;
   bit         prev_done = 0;
   bit         prev_valid = 0;
   logic [W-1:0] pa, pb, py;
   logic       pl;

   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 0;
         prev_done  = 0;
         prev_valid = 0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_a", bus.out_a, pa);
            check("hold_b", bus.out_b, pb);
            check("hold_y", bus.out_y, py);
            check("hold_last", bus.out_last, pl);
         end
         if (bus.out_valid && !prev_valid) rise_time = $time;
         if (bus.out_valid && bus.out_ready) begin
            check("beat_expected", beat_q.size() > 0, 1);
            if (beat_q.size() > 0) begin
               beat_t e;
               e = beat_q.pop_front();
               check("beat_a", bus.out_a, e.a);
               check("beat_b", bus.out_b, e.b);
               check("beat_y", bus.out_y, e.y);
               check("beat_last", bus.out_last, e.last);
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         pa = bus.out_a; pb = bus.out_b; py = bus.out_y; pl = bus.out_last;
         if (done) begin
            done_cnt++;
            done_time = $time;
            check("done_single_cycle", prev_done, 0);
            check("done_busy", busy, 1);
            check("done_expected", cnt_q.size() > 0, 1);
            if (cnt_q.size() > 0) check("match_count", match_count, cnt_q.pop_front());
         end
         prev_done  = done;
         prev_valid = bus.out_valid;
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", busy, 0);
   endtask

   task automatic run_sweep(input int unsigned op, input int unsigned inv, input bit noisy);
      int unsigned target;
      int          n = 0;
      bit          fast;
      time         t0;
      wait_idle();
      fast     = !rnd_ready && !stall_armed;
      start    = 1'b1;
      op_sel   = 3'(op);
      invert_b = inv[0];
      push_sweep(op, inv);
      target = done_cnt + 1;
      t0     = $time;
      @(negedge clk);
      check("valid_latency", bus.out_valid, 1);
      check("busy_run", busy, 1);
      start = 1'b0;
      while (done_cnt < target && n < 2000) begin
         if (noisy) begin
            start    = bus.out_valid ? 1'($urandom) : 1'b0;
            op_sel   = 3'($urandom);
            invert_b = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("done_seen", done_cnt, target);
      if (fast) check("done_latency", (done_time - t0) / 10, NB + 1);
      repeat (3) @(negedge clk);
      check("single_done", done_cnt, target);
   endtask

   task automatic held_start();
      int unsigned target;
      int          n = 0;
      time         t_first;
      wait_idle();
      start = 1'b1; op_sel = 3'd3; invert_b = 1'b1;
      push_sweep(3, 1);
      push_sweep(3, 1);
      target = done_cnt + 2;
      while (done_cnt < target - 1 && n < 2000) begin @(negedge clk); n++; end
      t_first = done_time;
      while (rise_time <= t_first && n < 2000) begin @(negedge clk); n++; end
      start = 1'b0;
      while (done_cnt < target && n < 2000) begin @(negedge clk); n++; end
      check("held_done_seen", done_cnt, target);
      check("held_idle_gap", (rise_time - t_first) / 10, 2);
   endtask

   task automatic reset_mid_run();
      int          n = 0;
      int unsigned saved;
      wait_idle();
      start = 1'b1; op_sel = 3'd1; invert_b = 1'b0;
      push_sweep(1, 0);
      @(negedge clk);
      start = 1'b0;
      while (!(bus.out_valid && bus.out_a == 1 && bus.out_b == 1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reached_beat5", bus.out_valid, 1);
      check("pre_reset_match_nonzero", match_count != 0, 1);
      saved = done_cnt;
      #2 reset = 1'b1;
      #1;
      check("rst_async_valid", bus.out_valid, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_match", match_count, 0);
      beat_q.delete();
      cnt_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_no_done", done_cnt, saved);
   endtask

   initial begin
      ttab[0] = 4'b0001; ttab[1] = 4'b0111; ttab[2] = 4'b1000; ttab[3] = 4'b1110;
      ttab[4] = 4'b0110; ttab[5] = 4'b1001; ttab[6] = 4'b0100; ttab[7] = 4'b1011;
      bus.out_ready = 1'b1;
      reset = 1'b1; start = 1'b0; op_sel = '0; invert_b = 1'b0;
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_a", bus.out_a, 0);
      check("rst_b", bus.out_b, 0);
      check("rst_y", bus.out_y, 0);
      check("rst_match", match_count, 0);
      @(negedge clk);
      reset = 1'b0;

      run_sweep(2, 0, 0);
      run_sweep(4, 0, 0);
      stall_armed = 1;
      run_sweep(2, 0, 0);
      check("stall_applied", stall_armed, 0);
      run_sweep(1, 0, 1);
      rnd_ready = 1;
      for (int i = 0; i < 8; i++) run_sweep($urandom % 8, $urandom % 2, 1'($urandom));
      rnd_ready = 0;
      held_start();
      reset_mid_run();
      run_sweep(0, 1, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
